// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC generation, instruction memory requests, buffering and decoder handshake with redirect flush.
module inst_fetch_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_rsp_valid,
  input  logic [31:0]     mem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  output logic [31:0]     dec_inst,
  output logic [XLEN-1:0] dec_pc,
  input  logic            dec_ready
);
  localparam int PW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, FETCH, STALL} state_t;
  state_t state, state_n;
  logic [XLEN-1:0] fetch_pc;
  // live counts only in-flight requests whose responses will be kept; stale ones sit in drop_cnt
  logic [CW-1:0] count, live, count_n, live_n;
  logic [7:0] drop_cnt, drop_n;
  logic [PW-1:0] rd, wr, tq_rd, tq_wr;
  logic [31:0] buf_inst [BUF_DEPTH];
  logic [XLEN-1:0] buf_pc [BUF_DEPTH];
  logic [XLEN-1:0] tq_pc [BUF_DEPTH];
  logic req_acc, rsp_any, rsp_drop, rsp_keep, pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  assign mem_req_valid = (state == FETCH) && !redirect_valid;
  assign mem_req_addr = fetch_pc;
  assign dec_valid = count != '0;
  assign dec_inst = dec_valid ? buf_inst[rd] : '0;
  assign dec_pc = dec_valid ? buf_pc[rd] : '0;
  assign req_acc = mem_req_valid && mem_req_ready;
  // responses with nothing outstanding (e.g. left over from before a reset) are ignored
  assign rsp_any = mem_rsp_valid && (live != '0 || drop_cnt != '0);
  assign rsp_drop = rsp_any && drop_cnt != '0;
  assign rsp_keep = rsp_any && drop_cnt == '0 && !redirect_valid;
  assign pop = dec_valid && dec_ready && !redirect_valid;
  always_comb begin
    live_n = redirect_valid ? '0 : live + CW'(req_acc) - CW'(rsp_any && drop_cnt == '0);
    drop_n = redirect_valid ? drop_cnt + 8'(live) - 8'(rsp_any) : drop_cnt - 8'(rsp_drop);
    count_n = redirect_valid ? '0 : count + CW'(rsp_keep) - CW'(pop);
    state_n = (state == IDLE || ({1'b0, count_n} + {1'b0, live_n}) < (CW+1)'(BUF_DEPTH)) ? FETCH : STALL;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      count <= '0;
      live <= '0;
      drop_cnt <= '0;
      rd <= '0;
      wr <= '0;
      tq_rd <= '0;
      tq_wr <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      live <= live_n;
      drop_cnt <= drop_n;
      fetch_pc <= redirect_valid ? redirect_pc & ~XLEN'(3) : req_acc ? fetch_pc + XLEN'(4) : fetch_pc;
      rd <= redirect_valid ? '0 : pop ? inc(rd) : rd;
      wr <= redirect_valid ? '0 : rsp_keep ? inc(wr) : wr;
      tq_rd <= redirect_valid ? '0 : rsp_keep ? inc(tq_rd) : tq_rd;
      tq_wr <= redirect_valid ? '0 : req_acc ? inc(tq_wr) : tq_wr;
    end
  always_ff @(posedge clk) begin
    if (rsp_keep) begin
      buf_inst[wr] <= mem_rsp_data;
      buf_pc[wr] <= tq_pc[tq_rd];
    end
    if (req_acc) tq_pc[tq_wr] <= fetch_pc;
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed per-cycle vectors against a 1-cycle-latency in-order memory model.
module tb_inst_fetch_unit;
  logic clk = 0, rstn = 0;
  logic mem_req_valid, mem_req_ready = 0, mem_rsp_valid = 0, redirect_valid = 0;
  logic dec_valid, dec_ready = 0;
  logic [31:0] mem_req_addr, mem_rsp_data = 0, redirect_pc = 0, dec_inst, dec_pc;
  int total = 0, bad = 0;
  logic [31:0] pend[$];
  logic acc = 0;
  logic [31:0] acc_a = 0;
  typedef struct {
    bit rst, rdy, drdy, ren, red;
    logic [31:0] rpc;
    bit erv;
    logic [31:0] era;
    bit edv;
    logic [31:0] edpc;
  } vec_t;
  vec_t tbl[$];
  inst_fetch_unit dut (
    .clk(clk), .rstn(rstn),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc), .dec_ready(dec_ready)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mk(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction
  function automatic vec_t v(input bit rst, rdy, drdy, ren, red, input logic [31:0] rpc,
                             input bit erv, input logic [31:0] era, input bit edv, input logic [31:0] edpc);
    vec_t r;
    r.rst = rst; r.rdy = rdy; r.drdy = drdy; r.ren = ren; r.red = red; r.rpc = rpc;
    r.erv = erv; r.era = era; r.edv = edv; r.edpc = edpc;
    return r;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    rstn = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; redirect_valid = 0; dec_ready = 0;
    pend.delete();
    acc = 0;
    @(posedge clk); #1;
    chk("rst_req_valid", 32'(mem_req_valid), 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_dec_valid", 32'(dec_valid), 0);
    chk("rst_dec_inst", dec_inst, 0);
    chk("rst_dec_pc", dec_pc, 0);
    @(posedge clk); #1;
    rstn = 1;
  endtask
  task automatic cyc(input bit rdy, drdy, ren, red, input logic [31:0] rpc, input bit erv,
                     input logic [31:0] era, input bit edv, input logic [31:0] edpc, input string nm);
    mem_req_ready = rdy; dec_ready = drdy; redirect_valid = red; redirect_pc = rpc;
    if (acc) pend.push_back(acc_a);
    if (ren && pend.size() > 0) begin
      mem_rsp_valid = 1;
      mem_rsp_data = mk(pend.pop_front());
    end else begin
      mem_rsp_valid = 0;
      mem_rsp_data = 0;
    end
    @(negedge clk);
    chk({nm, " req_valid"}, 32'(mem_req_valid), 32'(erv));
    if (erv) chk({nm, " req_addr"}, mem_req_addr, era);
    chk({nm, " dec_valid"}, 32'(dec_valid), 32'(edv));
    if (edv) begin
      chk({nm, " dec_pc"}, dec_pc, edpc);
      chk({nm, " dec_inst"}, dec_inst, mk(edpc));
    end
    acc = mem_req_valid && mem_req_ready;
    acc_a = mem_req_addr;
    @(posedge clk); #1;
  endtask
  initial begin
    // streaming with decoder always ready
    tbl.push_back(v(1,1,1,1,0,0, 0,0, 0,0));
    tbl.push_back(v(0,1,1,1,0,0, 1,0, 0,0));
    tbl.push_back(v(0,1,1,1,0,0, 1,4, 0,0));
    tbl.push_back(v(0,1,1,1,0,0, 0,0, 1,0));
    tbl.push_back(v(0,1,1,1,0,0, 1,8, 1,4));
    tbl.push_back(v(0,1,1,1,0,0, 1,'hC, 0,0));
    tbl.push_back(v(0,1,1,1,0,0, 0,0, 1,8));
    tbl.push_back(v(0,1,1,1,0,0, 1,'h10, 1,'hC));
    // decoder back-pressure fills the buffer, then resumes
    tbl.push_back(v(1,1,0,1,0,0, 0,0, 0,0));
    tbl.push_back(v(0,1,0,1,0,0, 1,0, 0,0));
    tbl.push_back(v(0,1,0,1,0,0, 1,4, 0,0));
    tbl.push_back(v(0,1,0,1,0,0, 0,0, 1,0));
    tbl.push_back(v(0,1,0,1,0,0, 0,0, 1,0));
    tbl.push_back(v(0,1,0,1,0,0, 0,0, 1,0));
    tbl.push_back(v(0,1,1,1,0,0, 0,0, 1,0));
    tbl.push_back(v(0,1,1,1,0,0, 1,8, 1,4));
    tbl.push_back(v(0,1,1,1,0,0, 1,'hC, 0,0));
    tbl.push_back(v(0,1,1,1,0,0, 0,0, 1,8));
    // two in flight (0x10, 0x14) dropped by redirect to 0x200
    tbl.push_back(v(1,1,1,0,0,0, 0,0, 0,0));
    tbl.push_back(v(0,1,1,0,1,'h10, 0,0, 0,0));
    tbl.push_back(v(0,1,1,0,0,0, 1,'h10, 0,0));
    tbl.push_back(v(0,1,1,0,0,0, 1,'h14, 0,0));
    tbl.push_back(v(0,1,1,0,1,'h200, 0,0, 0,0));
    tbl.push_back(v(0,1,1,1,0,0, 1,'h200, 0,0));
    tbl.push_back(v(0,1,1,1,0,0, 1,'h204, 0,0));
    tbl.push_back(v(0,1,1,1,0,0, 0,0, 0,0));
    tbl.push_back(v(0,1,1,1,0,0, 0,0, 1,'h200));
    tbl.push_back(v(0,1,1,1,0,0, 1,'h208, 1,'h204));
    // redirect in the same cycle as a kept response and a decoder pop
    tbl.push_back(v(1,1,1,1,0,0, 0,0, 0,0));
    tbl.push_back(v(0,1,1,1,0,0, 1,0, 0,0));
    tbl.push_back(v(0,1,1,1,0,0, 1,4, 0,0));
    tbl.push_back(v(0,1,1,1,1,'h40, 0,0, 1,0));
    tbl.push_back(v(0,1,1,1,0,0, 1,'h40, 0,0));
    tbl.push_back(v(0,1,1,1,0,0, 1,'h44, 0,0));
    tbl.push_back(v(0,1,1,1,0,0, 0,0, 1,'h40));
    tbl.push_back(v(0,1,1,1,0,0, 1,'h48, 1,'h44));
    // misaligned redirect target near the top of the address space wraps
    tbl.push_back(v(1,1,1,1,0,0, 0,0, 0,0));
    tbl.push_back(v(0,1,1,1,1,'hFFFF_FFFE, 0,0, 0,0));
    tbl.push_back(v(0,1,1,1,0,0, 1,'hFFFF_FFFC, 0,0));
    tbl.push_back(v(0,1,1,1,0,0, 1,0, 0,0));
    tbl.push_back(v(0,1,1,1,0,0, 0,0, 1,'hFFFF_FFFC));
    tbl.push_back(v(0,1,1,1,0,0, 1,4, 1,0));
    // back-to-back redirects accumulate three stale responses
    tbl.push_back(v(1,1,1,0,0,0, 0,0, 0,0));
    tbl.push_back(v(0,1,1,0,0,0, 1,0, 0,0));
    tbl.push_back(v(0,1,1,0,0,0, 1,4, 0,0));
    tbl.push_back(v(0,1,1,0,1,'h80, 0,0, 0,0));
    tbl.push_back(v(0,1,1,0,0,0, 1,'h80, 0,0));
    tbl.push_back(v(0,1,1,0,1,'hC0, 0,0, 0,0));
    tbl.push_back(v(0,1,1,1,0,0, 1,'hC0, 0,0));
    tbl.push_back(v(0,1,1,1,0,0, 1,'hC4, 0,0));
    tbl.push_back(v(0,1,1,1,0,0, 0,0, 0,0));
    tbl.push_back(v(0,1,1,1,0,0, 0,0, 0,0));
    tbl.push_back(v(0,1,1,1,0,0, 0,0, 1,'hC0));
    tbl.push_back(v(0,1,1,1,0,0, 1,'hC8, 1,'hC4));
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      cyc(tbl[i].rdy, tbl[i].drdy, tbl[i].ren, tbl[i].red, tbl[i].rpc, tbl[i].erv, tbl[i].era,
          tbl[i].edv, tbl[i].edpc, $sformatf("vec%0d", i));
    end
    // asynchronous reset mid-operation, then a late response before the first request
    do_reset();
    cyc(1,1,1,0,0, 0,0, 0,0, "ar_c0");
    cyc(1,1,1,0,0, 1,0, 0,0, "ar_c1");
    cyc(1,0,1,0,0, 1,4, 0,0, "ar_c2");
    #2;
    chk("ar_pre_dec_valid", 32'(dec_valid), 1);
    chk("ar_pre_req_addr", mem_req_addr, 8);
    rstn = 0;
    #1;
    chk("ar_req_valid", 32'(mem_req_valid), 0);
    chk("ar_req_addr", mem_req_addr, 0);
    chk("ar_dec_valid", 32'(dec_valid), 0);
    chk("ar_dec_inst", dec_inst, 0);
    chk("ar_dec_pc", dec_pc, 0);
    @(posedge clk); #1;
    rstn = 1;
    cyc(1,1,1,0,0, 0,0, 0,0, "ar_late_c0");
    cyc(1,1,1,0,0, 1,0, 0,0, "ar_late_c1");
    cyc(1,1,1,0,0, 1,4, 0,0, "ar_late_c2");
    cyc(1,1,1,0,0, 0,0, 1,0, "ar_late_c3");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
